// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, prioritised trap/branch/jump
// redirects, and a parked state after a misaligned branch or jump target.
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_pc,
  input  logic            stall,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid,
  output logic            redirect_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_target_o
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    WAIT_TRAP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};
  localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            valid_reg, valid_next;
  logic            redirect_reg, redirect_next;
  logic            misalign_reg, misalign_next;
  logic [XLEN-1:0] bad_reg, bad_next;

  logic            br_misaligned;
  logic            jmp_misaligned;
  logic [XLEN-1:0] trap_aligned;

  assign br_misaligned  = |(br_pc & LOW_MASK);
  assign jmp_misaligned = |(jmp_pc & LOW_MASK);
  // Trap targets are never rejected; the low bits are simply forced to zero.
  assign trap_aligned   = trap_pc & ~LOW_MASK;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    redirect_next = 1'b0;
    misalign_next = 1'b0;
    bad_next      = bad_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
        valid_next = 1'b1;
        if (trap_valid) begin
          pc_next       = trap_aligned;
          redirect_next = 1'b1;
        end
      end
      RUN: begin
        if (trap_valid) begin
          pc_next       = trap_aligned;
          redirect_next = 1'b1;
          valid_next    = 1'b1;
        end else if (br_valid) begin
          if (!br_misaligned) begin
            pc_next       = br_pc;
            redirect_next = 1'b1;
          end else begin
            misalign_next = 1'b1;
            bad_next      = br_pc;
            valid_next    = 1'b0;
            state_next    = WAIT_TRAP;
          end
        end else if (jmp_valid) begin
          // Only reached without a branch, so a younger jump never flags misalignment.
          if (!jmp_misaligned) begin
            pc_next       = jmp_pc;
            redirect_next = 1'b1;
          end else begin
            misalign_next = 1'b1;
            bad_next      = jmp_pc;
            valid_next    = 1'b0;
            state_next    = WAIT_TRAP;
          end
        end else if (valid_reg && if_ready && !stall) begin
          pc_next = pc_reg + INC_V;
        end
      end
      WAIT_TRAP: begin
        valid_next = 1'b0;
        if (trap_valid) begin
          pc_next       = trap_aligned;
          redirect_next = 1'b1;
          valid_next    = 1'b1;
          state_next    = RUN;
        end
      end
      default: begin
        state_next = BOOT;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VEC;
      valid_reg    <= 1'b0;
      redirect_reg <= 1'b0;
      misalign_reg <= 1'b0;
      bad_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      redirect_reg <= redirect_next;
      misalign_reg <= misalign_next;
      bad_reg      <= bad_next;
    end
  end

  assign pc_o         = pc_reg;
  assign pc_valid     = valid_reg;
  assign redirect_o   = redirect_reg;
  assign misalign_o   = misalign_reg;
  assign bad_target_o = bad_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed literal scenarios plus randomized traffic checked every
// cycle against an arithmetic reference model of the fetch PC.
module tb_pc_gen;

  localparam int ALN = 4;  // 2**ALIGN_BITS for the 32-bit instance

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_pc = '0;
  logic        stall = 1'b0;
  logic        if_ready = 1'b1;

  logic [31:0] pc_o;
  logic        pc_valid;
  logic        redirect_o;
  logic        misalign_o;
  logic [31:0] bad_target_o;

  logic [63:0] pc64;
  logic        valid64;
  logic        redirect64;
  logic        misalign64;
  logic [63:0] bad64;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_redirect;
  logic        m_misalign;
  logic [31:0] m_bad;
  logic        m_fresh;   // first edge after reset not yet taken
  logic        m_parked;  // waiting for a trap after a bad target

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .INC(4), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .jmp_valid(jmp_valid), .jmp_pc(jmp_pc),
    .stall(stall), .if_ready(if_ready),
    .pc_o(pc_o), .pc_valid(pc_valid),
    .redirect_o(redirect_o), .misalign_o(misalign_o), .bad_target_o(bad_target_o)
  );

  pc_gen #(.XLEN(64), .RESET_VEC(64'h0000_0000_8000_0000), .INC(4), .ALIGN_BITS(2)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(1'b0), .trap_pc(64'h0),
    .br_valid(1'b0), .br_pc(64'h0),
    .jmp_valid(1'b0), .jmp_pc(64'h0),
    .stall(1'b0), .if_ready(1'b0),
    .pc_o(pc64), .pc_valid(valid64),
    .redirect_o(redirect64), .misalign_o(misalign64), .bad_target_o(bad64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_redirect = 1'b0; m_misalign = 1'b0;
    m_bad = 32'h0; m_fresh = 1'b1; m_parked = 1'b0;
  endtask

  // Apply one br/jmp request to the model.
  task automatic model_target(input logic [31:0] tgt);
    if (tgt % ALN == 0) begin
      m_pc = tgt; m_redirect = 1'b1;
    end else begin
      m_misalign = 1'b1; m_bad = tgt; m_valid = 1'b0; m_parked = 1'b1;
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_redirect = 1'b0;
      m_misalign = 1'b0;
      if (trap_valid) begin
        m_pc = trap_pc - (trap_pc % ALN);
        m_redirect = 1'b1; m_valid = 1'b1; m_fresh = 1'b0; m_parked = 1'b0;
      end else if (m_fresh) begin
        m_fresh = 1'b0; m_valid = 1'b1;
      end else if (m_parked) begin
        m_valid = 1'b0;
      end else if (br_valid) begin
        model_target(br_pc);
      end else if (jmp_valid) begin
        model_target(jmp_pc);
      end else if (if_ready && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model();
    check("model_pc", 64'(pc_o), 64'(m_pc));
    check("model_valid", 64'(pc_valid), 64'(m_valid));
    check("model_redirect", 64'(redirect_o), 64'(m_redirect));
    check("model_misalign", 64'(misalign_o), 64'(m_misalign));
    check("model_bad", 64'(bad_target_o), 64'(m_bad));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
    $display("cyc t=%0t pc=%h v=%0b rd=%0b ma=%0b bad=%h", $time, pc_o, pc_valid,
             redirect_o, misalign_o, bad_target_o);
  endtask

  task automatic idle_inputs();
    trap_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; stall = 1'b0; if_ready = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, 64'(pc_o), 64'h0);
    check({tag, "_valid"}, 64'(pc_valid), 64'h0);
    check({tag, "_redirect"}, 64'(redirect_o), 64'h0);
    check({tag, "_misalign"}, 64'(misalign_o), 64'h0);
    check({tag, "_bad"}, 64'(bad_target_o), 64'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    model_reset();
    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;
    #1;
    check("boot_valid_low", 64'(pc_valid), 64'h0);

    // Sequential fetch from RESET_VEC, no pre-decrement
    step();
    check("first_pc", 64'(pc_o), 64'h0);
    check("first_valid", 64'(pc_valid), 64'h1);
    check("pc64_first", pc64, 64'h8000_0000);
    check("valid64_first", 64'(valid64), 64'h1);
    step(); check("seq_4", 64'(pc_o), 64'h4);
    step(); check("seq_8", 64'(pc_o), 64'h8);
    step(); check("seq_c", 64'(pc_o), 64'hC);
    step(); check("seq_10", 64'(pc_o), 64'h10);

    // Stall holds
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", 64'(pc_o), 64'h10);
    end
    stall = 1'b0;
    step(); check("after_stall", 64'(pc_o), 64'h14);

    // Branch beats jump, overrides stall
    jmp_valid = 1'b1; jmp_pc = 32'h20;
    step(); check("jmp_to_20", 64'(pc_o), 64'h20);
    br_valid = 1'b1; br_pc = 32'h100; jmp_valid = 1'b1; jmp_pc = 32'h200; stall = 1'b1;
    step();
    check("br_wins_pc", 64'(pc_o), 64'h100);
    check("br_redirect", 64'(redirect_o), 64'h1);
    check("br_valid_kept", 64'(pc_valid), 64'h1);
    idle_inputs();
    step();
    check("redirect_pulse_end", 64'(redirect_o), 64'h0);
    check("adv_after_br", 64'(pc_o), 64'h104);

    // Misaligned jump parks the generator
    jmp_valid = 1'b1; jmp_pc = 32'h102;
    step();
    check("mis_pulse", 64'(misalign_o), 64'h1);
    check("mis_bad", 64'(bad_target_o), 64'h102);
    check("mis_valid", 64'(pc_valid), 64'h0);
    check("mis_pc_kept", 64'(pc_o), 64'h104);
    jmp_valid = 1'b0; br_valid = 1'b1; br_pc = 32'h300;
    step();
    check("park_br_ignored", 64'(pc_o), 64'h104);
    check("park_mis_end", 64'(misalign_o), 64'h0);
    check("park_bad_held", 64'(bad_target_o), 64'h102);
    br_valid = 1'b0; trap_valid = 1'b1; trap_pc = 32'h8000_0007;
    step();
    check("trap_pc_aligned", 64'(pc_o), 64'h8000_0004);
    check("trap_valid_back", 64'(pc_valid), 64'h1);
    check("trap_redirect", 64'(redirect_o), 64'h1);

    // Wrap at the top of the address space
    trap_pc = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    step(); check("wrap_zero", 64'(pc_o), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      trap_valid = ($urandom_range(0, 15) == 0);
      br_valid   = ($urandom_range(0, 7) == 0);
      jmp_valid  = ($urandom_range(0, 7) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      if_ready   = ($urandom_range(0, 3) != 0);
      tgt = $urandom(); if ($urandom_range(0, 3) != 0) tgt = tgt - (tgt % ALN);
      trap_pc = $urandom();
      br_pc = tgt;
      tgt = $urandom(); if ($urandom_range(0, 3) != 0) tgt = tgt - (tgt % ALN);
      jmp_pc = tgt;
      step();
    end

    // Asynchronous reset mid-advance
    idle_inputs();
    trap_valid = 1'b1; trap_pc = 32'h40;
    step();
    trap_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_run");
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    jmp_valid = 1'b1; jmp_pc = 32'h6;
    step();
    check("park_again", 64'(misalign_o), 64'h1);
    jmp_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_wait");
    model_reset();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
